// File: rtl/dbg_probe_unit.sv
// Debug controller for the MIPS pipeline. It takes byte commands, gates the pipeline clock enable,
// and streams probe or cycle-count snapshots back over a byte TX link, least significant byte first.
module dbg_probe_unit #(
    parameter int NUM_PROBES = 32,
    parameter int PROBE_W    = 32,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [NUM_PROBES*PROBE_W-1:0] probes,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          pipe_en,
    output logic                          running,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    localparam logic [5:0] OP_STEP = 6'h38;
    localparam logic [5:0] OP_RUN  = 6'h39;
    localparam logic [5:0] OP_HALT = 6'h3A;
    localparam logic [5:0] OP_CNT  = 6'h3B;

    logic [1:0]  state;
    logic [31:0] snapshot;
    logic [1:0]  remaining;
    logic [5:0]  op;
    logic [1:0]  size;
    logic [31:0] probe_word;
    logic [31:0] read_word;
    logic [63:0] cnt_ext;

    assign op      = cmd_data[5:0];
    assign size    = cmd_data[7:6];
    assign cnt_ext = 64'(cycle_count);

    // Unmapped and reserved indices never match, so they read as zero.
    always_comb begin
        probe_word = '0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (op == 6'(k)) probe_word = 32'(probes[k*PROBE_W +: PROBE_W]);
        end
    end

    assign read_word = (op == OP_CNT) ? cnt_ext[31:0] : probe_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            pipe_en     <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
            snapshot    <= '0;
            remaining   <= '0;
        end else begin
            if (pipe_en) cycle_count <= cycle_count + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        case (op)
                            OP_STEP: begin
                                pipe_en <= 1'b1;
                                state   <= S_STEP;
                            end
                            OP_RUN, OP_HALT: begin
                                running   <= (op == OP_RUN);
                                pipe_en   <= (op == OP_RUN);
                                tx_data   <= (op == OP_RUN) ? 8'h55 : 8'hAA;
                                tx_valid  <= 1'b1;
                                remaining <= 2'd0;
                                state     <= S_SEND;
                            end
                            default: begin
                                snapshot  <= read_word;
                                tx_data   <= read_word[7:0];
                                tx_valid  <= 1'b1;
                                remaining <= size;
                                state     <= S_SEND;
                            end
                        endcase
                    end
                end
                S_STEP: begin
                    // A step issued while free-running leaves the enable high.
                    pipe_en   <= running;
                    tx_data   <= 8'h55;
                    tx_valid  <= 1'b1;
                    remaining <= 2'd0;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (remaining == 2'd0) begin
                            tx_valid  <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            remaining <= remaining - 2'd1;
                            snapshot  <= snapshot >> 8;
                            tx_data   <= snapshot[15:8];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_probe_unit.sv
// Scoreboard bench for dbg_probe_unit: directed commands push expected TX bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_dbg_probe_unit;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    cmd_data, cmd2_data;
    logic          cmd_valid, cmd2_valid;
    logic          cmd_ready, cmd2_ready;
    logic [1023:0] probes;
    logic [31:0]   probes2;
    logic [7:0]    tx_data, tx2_data;
    logic          tx_valid, tx2_valid;
    logic          tx_ready;
    logic          pipe_en, pipe_en2;
    logic          running, running2;
    logic [31:0]   cycle_count;
    logic [7:0]    cycle_count2;

    always #5 clk = ~clk;

    dbg_probe_unit #(.NUM_PROBES(32), .PROBE_W(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .probes(probes), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pipe_en(pipe_en), .running(running), .cycle_count(cycle_count));

    dbg_probe_unit #(.NUM_PROBES(4), .PROBE_W(8), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .cmd_data(cmd2_data), .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready),
        .probes(probes2), .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(tx_ready),
        .pipe_en(pipe_en2), .running(running2), .cycle_count(cycle_count2));

    int vectors = 0;
    int miscompares = 0;
    int total_pe = 0;
    int pe_rises = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic push4(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((w >> (8*i)) & 32'hFF));
    endtask

    // Monitor: pops expected bytes on every accepted transfer and checks stall stability.
    initial begin
        logic       prev_stall, prev_pe;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_pe    = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_pe    = 1'b0;
                total_pe   = 0;
            end else begin
                if (pipe_en) total_pe++;
                if (pipe_en && !prev_pe) pe_rises++;
                if (prev_stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) fail_now("tx_unexpected_byte");
                    else check("tx_byte", tx_data, exp_q.pop_front());
                end
                if (tx2_valid && tx_ready) begin
                    if (exp2_q.size() == 0) fail_now("tx2_unexpected_byte");
                    else check("tx2_byte", tx2_data, exp2_q.pop_front());
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_pe    = pipe_en;
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int n = 0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] c);
        int n = 0;
        cmd2_data  = c;
        cmd2_valid = 1'b1;
        @(negedge clk);
        while (!cmd2_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd2_ready) begin
            fail_now("cmd2_accept_timeout");
            cmd2_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd2_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && exp2_q.size() == 0 && cmd_ready && cmd2_ready) && n < 500);
        if (n >= 500) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        cmd_data   = '0;
        cmd_valid  = 1'b0;
        cmd2_data  = '0;
        cmd2_valid = 1'b0;
        tx_ready   = 1'b1;
        for (int k = 0; k < 32; k++) probes[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        probes[5*32 +: 32] = 32'hDEADBEEF;
        probes2 = {8'h33, 8'h22, 8'h11, 8'hFF};

        // Reset values and cmd_ready rising only at the first edge after release
        #12;
        check("reset_outputs", {cmd_ready, tx_valid, tx_data, pipe_en, running, cycle_count}, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", cmd_ready, 1);

        // T1: 4-byte read, busy exactly 4 cycles
        push4(32'hDEADBEEF, 4);
        send(8'hC5);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        check("t1_busy_cycles", n, 4);
        drain();

        // T2: 2-byte read under toggling backpressure
        tx_ready = 1'b0;
        push4(32'hDEADBEEF, 2);
        send(8'h45);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
        drain();

        // T3: three single steps, then cycle count readback
        pe_rises = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h55);
            send(8'h38);
            drain();
        end
        check("t3_pulses", pe_rises, 3);
        check("t3_pe_cycles", total_pe, 3);
        check("t3_pipe_en_low", pipe_en, 0);
        push4(32'h3, 4);
        send(8'hFB);
        drain();
        check("t3_cycle_count", cycle_count, 3);

        // T4: free run for 100+ cycles, then halt
        exp_q.push_back(8'h55);
        send(8'h39);
        repeat (100) @(posedge clk);
        #1 check("t4_running", {running, pipe_en}, 2'b11);
        exp_q.push_back(8'hAA);
        send(8'h3A);
        drain();
        check("t4_halted", {running, pipe_en}, 2'b00);
        check("t4_min_cycles", total_pe >= 104, 1);
        check("t4_cycle_count", cycle_count, 64'(total_pe));
        push4(32'(total_pe), 4);
        send(8'hFB);
        drain();
        exp_q.push_back(8'hAA);
        send(8'h3A);
        drain();

        // T5: unmapped and reserved opcodes, narrow probe zero-extension
        exp_q.push_back(8'h00);
        send(8'h30);
        push4(32'h0, 2);
        send(8'h7E);
        drain();
        exp2_q.push_back(8'hFF); exp2_q.push_back(8'h00);
        exp2_q.push_back(8'h00); exp2_q.push_back(8'h00);
        send2(8'hC0);
        drain();
        exp2_q.push_back(8'h33);
        send2(8'h03);
        exp2_q.push_back(8'h00); exp2_q.push_back(8'h00);
        send2(8'h45);
        drain();

        // T6: reset during the 2nd byte of a 4-byte read while running
        exp_q.push_back(8'h55);
        send(8'h39);
        drain();
        push4(32'hDEADBEEF, 4);
        send(8'hC5);
        @(posedge clk);
        #1 check("t6_second_byte", {tx_valid, tx_data}, {1'b1, 8'hBE});
        reset = 1'b1;
        #1 check("t6_async_reset", {cmd_ready, tx_valid, tx_data, pipe_en, running, cycle_count}, '0);
        exp_q.delete();
        #20;
        @(posedge clk);
        #1 reset = 1'b0;
        push4(32'hDEADBEEF, 4);
        send(8'hC5);
        drain();
        check("t6_count_cleared", {running, cycle_count}, '0);
        check("queues_empty", exp_q.size() + exp2_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
